lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 Parameter CNT_WIDTH, default 14: width of each bin counter and of the total counter.
REQ-002 Parameter NUM_BINS, default 256: number of histogram bins, equal to 2^8 for 8-bit LBP codes.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lbp_valid  input  1  LBP sample strobe; one code per cycle while high.
REQ-006 lbp_addr  input  14  pixel address of the sample, {row[6:0], col[6:0]}.
REQ-007 lbp_data  input  8  LBP code; selects the bin to increment.
REQ-008 finish  input  1  one-cycle pulse from the LBP stage marking end of image.
REQ-009 hist_valid  output  1  dump word valid.
REQ-010 hist_ready  input  1  downstream accepts the dump word.
REQ-011 hist_bin  output  8  bin index of the current dump word.
REQ-012 hist_count  output  CNT_WIDTH  count of the current dump word.
REQ-013 hist_done  output  1  one-cycle pulse after the last dump word is accepted.
REQ-014 total_cnt  output  CNT_WIDTH  number of samples accepted this frame, saturating.
REQ-015 seq_err  output  1  sticky error flag: bad address order or sample while dumping.

Function
REQ-016 FSM states: IDLE, ACCUM, DRAIN, DUMP, DONE.
REQ-017 IDLE -> ACCUM on lbp_valid; that sample is counted.
REQ-018 ACCUM: every lbp_valid cycle adds 1 to bin[lbp_data] and to total_cnt in the same edge.
REQ-019 Bin and total counters saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-020 ACCUM -> DRAIN on finish; a sample arriving in that same cycle is counted.
REQ-021 DRAIN lasts exactly one cycle and counts a lbp_valid present in it; this covers the LBP stage's registered lbp_valid, which trails finish by one cycle.
REQ-022 DRAIN -> DUMP unconditionally.
REQ-023 finish received in IDLE moves the FSM to DRAIN, so an empty frame still dumps all zeros.
REQ-024 DUMP presents bins in ascending order starting at bin 0; hist_valid is high throughout DUMP.
REQ-025 A word transfers when hist_valid and hist_ready are both high; hist_bin advances on the next edge.
REQ-026 hist_bin and hist_count hold stable while hist_valid=1 and hist_ready=0.
REQ-027 DUMP -> DONE on transfer of the last bin.
REQ-028 DONE lasts one cycle: hist_done=1, all bins and total_cnt clear on the next edge, then the FSM returns to IDLE.
REQ-029 In ACCUM, an lbp_addr not strictly greater than the previous accepted lbp_addr sets seq_err; the sample is still counted.
REQ-030 lbp_valid in DUMP or DONE is ignored and sets seq_err.
REQ-031 seq_err clears only on reset.
REQ-032 finish in DUMP or DONE is ignored.

Reset
REQ-033 On reset the FSM enters IDLE; all bins, total_cnt, the last-address register and seq_err go to 0.
REQ-034 Output reset values: hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, total_cnt=0, seq_err=0.
REQ-035 Reset asserted in any state, including mid-dump, takes effect at the next edge and aborts the frame; no hist_done is issued.

Configuration
REQ-036 Macro LBP_HIST_SKIP_ZERO_EN.
- Defined: DUMP presents only bins with nonzero count, still in ascending order.
- Defined: if every bin is zero, DUMP presents no words and goes straight to DONE.
- Defined: the last word is the highest nonzero bin.
- Undefined: all NUM_BINS bins are dumped.

Verification
REQ-037 Samples lbp_data=5 x3 and 200 x1 at ascending addresses, finish, hist_ready=1 -> 256 words; bin5=3, bin200=1, others 0; total_cnt=4; hist_done one cycle after bin 255.
REQ-038 finish with lbp_valid (code 7) in the next cycle -> sample counted in DRAIN; bin7=1.
REQ-039 hist_ready toggled 0/1 each cycle during dump -> every word stable while stalled; no bin lost or duplicated.
REQ-040 Same lbp_addr twice, then a sample during DUMP -> seq_err=1, stays set after hist_done, clears only on reset.
REQ-041 2^CNT_WIDTH+3 samples of code 0 -> bin0 and total_cnt saturate at 16383.
REQ-042 Reset asserted at dump bin 100 -> next cycle hist_valid=0, all counts 0, no hist_done; with LBP_HIST_SKIP_ZERO_EN defined, the REQ-037 stimulus yields exactly 2 words.

Source files
------------

// File: rtl/lbp_hist.sv
// LBP code histogram: counts 8-bit LBP codes per frame, then streams the bins out.
// Optional macro LBP_HIST_SKIP_ZERO_EN: the dump presents only nonzero bins.
module lbp_hist #(
  parameter int CNT_WIDTH = 14,
  parameter int NUM_BINS  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lbp_valid,
  input  logic [13:0]          lbp_addr,
  input  logic [7:0]           lbp_data,
  input  logic                 finish,
  output logic                 hist_valid,
  input  logic                 hist_ready,
  output logic [7:0]           hist_bin,
  output logic [CNT_WIDTH-1:0] hist_count,
  output logic                 hist_done,
  output logic [CNT_WIDTH-1:0] total_cnt,
  output logic                 seq_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [7:0]           LAST_BIN = 8'(NUM_BINS - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, DUMP, DONE} state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] bins_q [NUM_BINS];
  logic [CNT_WIDTH-1:0] bins_d [NUM_BINS];
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [13:0]          lastAddr_q;
  logic                 seqErr_q;
  logic                 histValid_q;
  logic                 histDone_q;
  logic [7:0]           histBin_q;

  logic                 accept;
  logic                 seqErrSet;
  logic                 firstFound;
  logic [7:0]           firstBin;
  logic                 nextFound;
  logic [7:0]           nextBin;

  assign accept = lbp_valid && (state_q == IDLE || state_q == ACCUM || state_q == DRAIN);

  assign seqErrSet = (lbp_valid && (state_q == DUMP || state_q == DONE)) ||
                     (lbp_valid && state_q == ACCUM && (lbp_addr <= lastAddr_q));

  always_comb begin
    bins_d  = bins_q;
    total_d = total_q;
    if (state_q == DONE) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_d[i] = '0;
      end
      total_d = '0;
    end else if (accept) begin
      if (bins_q[lbp_data] != CNT_MAX) begin
        bins_d[lbp_data] = bins_q[lbp_data] + CNT_ONE;
      end
      if (total_q != CNT_MAX) begin
        total_d = total_q + CNT_ONE;
      end
    end
  end

`ifdef LBP_HIST_SKIP_ZERO_EN
  // Descending scan so the lowest matching bin is the one left standing.
  // The first search looks at bins_d so a sample counted in DRAIN is seen.
  always_comb begin
    firstFound = 1'b0;
    firstBin   = '0;
    nextFound  = 1'b0;
    nextBin    = '0;
    for (int i = NUM_BINS - 1; i >= 0; i--) begin
      if (bins_d[i] != '0) begin
        firstFound = 1'b1;
        firstBin   = 8'(i);
      end
      if (bins_q[i] != '0 && 8'(i) > histBin_q) begin
        nextFound = 1'b1;
        nextBin   = 8'(i);
      end
    end
  end
`else
  always_comb begin
    firstFound = 1'b1;
    firstBin   = '0;
    nextFound  = (histBin_q != LAST_BIN);
    nextBin    = histBin_q + 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      histBin_q   <= '0;
      histValid_q <= 1'b0;
      histDone_q  <= 1'b0;
    end else begin
      histDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (finish) begin
            state_q <= DRAIN;
          end else if (lbp_valid) begin
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (finish) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (firstFound) begin
            state_q     <= DUMP;
            histBin_q   <= firstBin;
            histValid_q <= 1'b1;
          end else begin
            state_q    <= DONE;
            histDone_q <= 1'b1;
          end
        end
        DUMP: begin
          if (hist_ready) begin
            if (nextFound) begin
              histBin_q <= nextBin;
            end else begin
              state_q     <= DONE;
              histValid_q <= 1'b0;
              histDone_q  <= 1'b1;
              histBin_q   <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_q[i] <= '0;
      end
      total_q    <= '0;
      lastAddr_q <= '0;
      seqErr_q   <= 1'b0;
    end else begin
      bins_q  <= bins_d;
      total_q <= total_d;
      if (accept) begin
        lastAddr_q <= lbp_addr;
      end
      if (seqErrSet) begin
        seqErr_q <= 1'b1;
      end
    end
  end

  assign hist_valid = histValid_q;
  assign hist_bin   = histBin_q;
  assign hist_count = histValid_q ? bins_q[histBin_q] : '0;
  assign hist_done  = histDone_q;
  assign total_cnt  = total_q;
  assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: directed frames, expected dump words queued by a small model.
module tb_lbp_hist;

  logic        clk;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_valid;
  logic        hist_ready;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_done;
  logic [13:0] total_cnt;
  logic        seq_err;

  typedef struct {
    logic [7:0]  bin;
    logic [13:0] count;
    bit          last;
  } word_t;

  word_t       expQ[$];
  word_t       popped;
  int          modelBins [256];
  int          checks = 0;
  int          fails = 0;
  int          doneCount = 0;
  bit          doneExpectNext = 0;
  bit          nextDone;
  bit          stallHeld = 0;
  logic [7:0]  stallBin;
  logic [13:0] stallCount;

  lbp_hist #(.CNT_WIDTH(14), .NUM_BINS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .hist_valid(hist_valid),
    .hist_ready(hist_ready),
    .hist_bin  (hist_bin),
    .hist_count(hist_count),
    .hist_done (hist_done),
    .total_cnt (total_cnt),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expd);
    checks++;
    if (act !== expd) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [13:0] a, input logic [7:0] d, input logic f);
    lbp_valid = v;
    lbp_addr  = a;
    lbp_data  = d;
    finish    = f;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic sample(input logic [13:0] a, input logic [7:0] d);
    if (modelBins[d] < 16383) modelBins[d]++;
    applyStimulus(1'b1, a, d, 1'b0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) modelBins[i] = 0;
  endtask

  // Queue the words the next dump should produce, marking the final one.
  task automatic pushDump();
    int lastIdx;
    lastIdx = -1;
    for (int i = 0; i < 256; i++) begin
`ifdef LBP_HIST_SKIP_ZERO_EN
      if (modelBins[i] != 0) lastIdx = i;
`else
      lastIdx = i;
`endif
    end
    for (int i = 0; i <= lastIdx; i++) begin
`ifdef LBP_HIST_SKIP_ZERO_EN
      if (modelBins[i] == 0) continue;
`endif
      expQ.push_back('{bin: 8'(i), count: 14'(modelBins[i]), last: (i == lastIdx)});
    end
    clearModel();
  endtask

  task automatic runDump(input bit toggle);
    int start;
    int cyc;
    start = doneCount;
    cyc = 0;
    hist_ready = 1'b1;
    while (doneCount == start && cyc < 3000) begin
      if (toggle) hist_ready = ~hist_ready;
      tick();
      cyc++;
    end
    hist_ready = 1'b0;
    checkOutput("dump_completed", 32'(doneCount - start), 32'd1);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability and hist_done timing.
  always @(negedge clk) begin
    if (reset) begin
      stallHeld      = 0;
      doneExpectNext = 0;
    end else begin
      if (doneExpectNext || hist_done) begin
        checkOutput("hist_done_timing", 32'(hist_done), 32'(doneExpectNext));
      end
      if (hist_done) doneCount++;
      nextDone = 0;
      if (hist_valid) begin
        if (stallHeld) begin
          checkOutput("stall_bin", 32'(hist_bin), 32'(stallBin));
          checkOutput("stall_count", 32'(hist_count), 32'(stallCount));
        end
        if (hist_ready) begin
          stallHeld = 0;
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_word: got bin %0d count %0d, expected no word", hist_bin, hist_count);
          end else begin
            popped = expQ.pop_front();
            checkOutput("word_bin", 32'(hist_bin), 32'(popped.bin));
            checkOutput("word_count", 32'(hist_count), 32'(popped.count));
            nextDone = popped.last;
          end
        end else begin
          stallHeld  = 1;
          stallBin   = hist_bin;
          stallCount = hist_count;
        end
      end else begin
        stallHeld = 0;
      end
      doneExpectNext = nextDone;
    end
  end

  initial begin
    int cyc;
    int doneBefore;
    clk = 1'b0;
    reset = 1'b1;
    lbp_valid = 1'b0;
    lbp_addr = '0;
    lbp_data = '0;
    finish = 1'b0;
    hist_ready = 1'b0;
    clearModel();
    tick();
    tick();
    checkOutput("rst_hist_valid", 32'(hist_valid), 32'd0);
    checkOutput("rst_hist_bin", 32'(hist_bin), 32'd0);
    checkOutput("rst_hist_count", 32'(hist_count), 32'd0);
    checkOutput("rst_hist_done", 32'(hist_done), 32'd0);
    checkOutput("rst_total_cnt", 32'(total_cnt), 32'd0);
    checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] frame A: codes 5,5,5,200");
    sample(14'd1, 8'd5);
    sample(14'd2, 8'd5);
    sample(14'd3, 8'd5);
    sample(14'd4, 8'd200);
    checkOutput("A_total", 32'(total_cnt), 32'd4);
    pushDump();
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    runDump(1'b0);
    checkOutput("A_total_cleared", 32'(total_cnt), 32'd0);
    checkOutput("A_seq_err", 32'(seq_err), 32'd0);

    $display("[TB] frame B: sample trailing finish, stalled dump");
    sample(14'd10, 8'd3);
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    sample(14'd11, 8'd7);
    checkOutput("B_total", 32'(total_cnt), 32'd2);
    checkOutput("B_dump_started", 32'(hist_valid), 32'd1);
    pushDump();
    runDump(1'b1);

    $display("[TB] frame C: sequence errors");
    doReset();
    sample(14'd20, 8'd1);
    sample(14'd20, 8'd2);
    checkOutput("C_seq_err_dup", 32'(seq_err), 32'd1);
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    tick();
    pushDump();
    applyStimulus(1'b1, 14'd100, 8'd255, 1'b0);
    runDump(1'b0);
    checkOutput("C_seq_err_sticky", 32'(seq_err), 32'd1);
    doReset();
    checkOutput("C_seq_err_cleared", 32'(seq_err), 32'd0);

    $display("[TB] frame D: saturation");
    for (int i = 0; i < 16387; i++) begin
      sample(14'(i), 8'd0);
    end
    checkOutput("D_total_sat", 32'(total_cnt), 32'd16383);
    pushDump();
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    runDump(1'b0);
    doReset();

`ifndef LBP_HIST_SKIP_ZERO_EN
    $display("[TB] frame E: reset mid-dump");
    sample(14'd1, 8'd50);
    sample(14'd2, 8'd50);
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      expQ.push_back('{bin: 8'(i), count: (i == 50) ? 14'd2 : 14'd0, last: 1'b0});
    end
    clearModel();
    doneBefore = doneCount;
    hist_ready = 1'b1;
    cyc = 0;
    while (!(hist_valid && hist_bin == 8'd100) && cyc < 1000) begin
      tick();
      cyc++;
    end
    checkOutput("E_reached_bin100", 32'(hist_bin), 32'd100);
    hist_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("E_valid_after_rst", 32'(hist_valid), 32'd0);
    checkOutput("E_count_after_rst", 32'(hist_count), 32'd0);
    checkOutput("E_total_after_rst", 32'(total_cnt), 32'd0);
    checkOutput("E_words_before_abort", 32'(expQ.size()), 32'd0);
    repeat (5) tick();
    checkOutput("E_no_done", 32'(doneCount - doneBefore), 32'd0);

    $display("[TB] frame F: empty frame dumps zeros");
    pushDump();
    applyStimulus(1'b0, 14'd0, 8'd0, 1'b1);
    runDump(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
